// File: rtl/mux_8x1_rr_pkg.sv
// Shared types and constants for the 8-channel round-robin stream mux.
package mux_8x1_rr_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic {
    ST_ARB,
    ST_LOCK
  } state_t;

  typedef logic [SEL_W-1:0] ch_idx_t;

endpackage

// File: rtl/mux_8x1_rr_arbiter.sv
// Combinational round-robin picker: scans from last_grant+1 upward, wrapping,
// and grants the first requester found.
module rr_arbiter_8
  import mux_8x1_rr_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic [SEL_W-1:0] cand;

  // Walk from lowest to highest priority so the nearest requester overwrites.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = int'(NUM_CH); k >= 1; k--) begin
      cand = last_grant + SEL_W'(k);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_8x1_rr.sv
// 8:1 stream mux with round-robin arbitration, packet locking and a
// one-deep registered output stage tagged with the source channel.
module mux_8x1_rr
  import mux_8x1_rr_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = mux_8x1_rr_pkg::NUM_CH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_last,
  input  logic                     out_ready
);

  state_t            state;
  logic [SEL_W-1:0]  last_grant;
  logic [SEL_W-1:0]  lock_ch;

  logic              arb_valid;
  logic [SEL_W-1:0]  arb_idx;
  logic              gnt_valid;
  logic [SEL_W-1:0]  gnt_idx;
  logic              can_load;
  logic              xfer;
  logic [DATA_W-1:0] beat_data;
  logic              beat_last;

  rr_arbiter_8 u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .gnt_valid  (arb_valid),
    .gnt_idx    (arb_idx)
  );

  // While locked only the owning channel may be granted, even if others wait.
  always_comb begin
    can_load  = !out_valid || out_ready;
    gnt_valid = arb_valid;
    gnt_idx   = arb_idx;
    if (state == ST_LOCK) begin
      gnt_valid = in_valid[lock_ch];
      gnt_idx   = lock_ch;
    end
    in_ready = '0;
    if (can_load && gnt_valid) begin
      in_ready[gnt_idx] = 1'b1;
    end
    xfer      = can_load && gnt_valid;
    beat_data = in_data[gnt_idx*DATA_W +: DATA_W];
    beat_last = in_last[gnt_idx];
  end

  // Output register, lock FSM and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_ARB;
      lock_ch    <= '0;
      last_grant <= SEL_W'(NUM_CH - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      out_last   <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid  <= 1'b1;
        out_data   <= beat_data;
        out_sel    <= gnt_idx;
        out_last   <= beat_last;
        last_grant <= gnt_idx;
        case (state)
          ST_ARB: begin
            if (!beat_last) begin
              state   <= ST_LOCK;
              lock_ch <= gnt_idx;
            end
          end
          ST_LOCK: begin
            if (beat_last) begin
              state <= ST_ARB;
            end
          end
          default: state <= ST_ARB;
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_8x1_rr.sv
// Scoreboard bench for mux_8x1_rr: directed scenarios followed by random
// traffic, checked against a cycle-level behavioural model.
module tb_mux_8x1_rr;

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  v;
  logic [7:0]  l;
  logic [7:0]  d [8];
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_last;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t      exp_q[$];
  logic [2:0] sel_log[$];

  // Model state: output-register occupancy, last granted channel, locked channel (-1 = none)
  logic m_ov;
  int   m_last;
  int   m_lock;
  int   xfer_ch;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = d[i];
  end

  mux_8x1_rr #(.DATA_W(8), .NUM_CH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v),
    .in_last   (l),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Predicts grant/in_ready from the arbitration rules and records the expected beat.
  task automatic model_check();
    int g;
    logic [7:0] er;
    xfer_ch = -1;
    if (!rst_n) begin
      m_ov   = 1'b0;
      m_last = 7;
      m_lock = -1;
      exp_q.delete();
      return;
    end
    check("out_valid", 32'(out_valid), 32'(m_ov));
    g = -1;
    if (m_lock >= 0) begin
      if (v[m_lock]) g = m_lock;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        if (g < 0 && v[(m_last + k) % 8]) g = (m_last + k) % 8;
      end
    end
    er = '0;
    if ((!m_ov || out_ready) && g >= 0) er[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(er));
    if (er != 0) begin
      exp_q.push_back('{data: d[g], sel: 3'(g), last: l[g]});
      m_ov    = 1'b1;
      m_last  = g;
      m_lock  = l[g] ? -1 : g;
      xfer_ch = g;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the head of the scoreboard.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          b = exp_q[0];
          check("out_data", 32'(out_data), 32'(b.data));
          check("out_sel",  32'(out_sel),  32'(b.sel));
          check("out_last", 32'(out_last), 32'(b.last));
          if (out_ready) begin
            void'(exp_q.pop_front());
            sel_log.push_back(out_sel);
          end
        end
      end
    end
  end

  initial begin
    int k;
    logic [2:0] pkt_sel [4];
    rst_n = 1'b0; v = '0; l = '0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = '0;
    m_ov = 1'b0; m_last = 7; m_lock = -1; xfer_ch = -1;

    // Reset then idle
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_out_sel",  32'(out_sel), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_out_data", 32'(out_data), 32'd0);
    end

    // Round-robin over single-beat packets
    sel_log.delete();
    v = 8'hFF; l = 8'hFF;
    for (int i = 0; i < 8; i++) d[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 10; i++) tick();
    v = '0;
    tick(); tick();
    check("rr_count", 32'(sel_log.size() >= 9), 32'd1);
    if (sel_log.size() >= 9) begin
      for (int i = 0; i < 9; i++) check("rr_seq", 32'(sel_log[i]), 32'(i % 8));
    end

    // Packet lock: ch2 three beats while ch5 waits
    sel_log.delete();
    v[2] = 1'b1; d[2] = 8'h11; l[2] = 1'b0;
    tick();
    v[5] = 1'b1; d[5] = 8'h55; l[5] = 1'b1;
    k = 1;
    for (int c = 0; c < 12; c++) begin
      if (xfer_ch == 2) begin
        if (k == 1) begin d[2] = 8'h22; l[2] = 1'b0; end
        else if (k == 2) begin d[2] = 8'h33; l[2] = 1'b1; end
        else v[2] = 1'b0;
        k++;
      end
      if (xfer_ch == 5) v[5] = 1'b0;
      if (v[2]) check("lock_rdy5", 32'(in_ready[5]), 32'd0);
      tick();
    end
    pkt_sel[0] = 3'd2; pkt_sel[1] = 3'd2; pkt_sel[2] = 3'd2; pkt_sel[3] = 3'd5;
    check("pkt_count", 32'(sel_log.size()), 32'd4);
    if (sel_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("pkt_seq", 32'(sel_log[i]), 32'(pkt_sel[i]));
    end

    // Backpressure on a pending ch3 beat
    v = '0; v[3] = 1'b1; d[3] = 8'h5A; l[3] = 1'b1;
    tick();
    d[3] = 8'h6B; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_data",  32'(out_data), 32'h5A);
      check("bp_sel",   32'(out_sel),  32'd3);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_reload_valid", 32'(out_valid), 32'd1);
    check("bp_reload_data",  32'(out_data),  32'h6B);
    v = '0;
    tick();

    // Lock stall: ch1 pauses mid-packet while ch4 requests
    v[1] = 1'b1; d[1] = 8'hC1; l[1] = 1'b0;
    tick();
    v[1] = 1'b0; v[4] = 1'b1; d[4] = 8'h44; l[4] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rdy4", 32'(in_ready[4]), 32'd0);
      if (i > 0) check("stall_idle", 32'(out_valid), 32'd0);
    end
    v[1] = 1'b1; d[1] = 8'hC2; l[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (xfer_ch == 1) v[1] = 1'b0;
      if (xfer_ch == 4) v[4] = 1'b0;
    end

    // Reset while locked to ch6 with a beat held in the output register
    out_ready = 1'b0;
    v = '0; v[6] = 1'b1; d[6] = 8'h66; l[6] = 1'b0;
    tick();
    d[6] = 8'h67;
    rst_n = 1'b0;
    tick();
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    v[0] = 1'b1; d[0] = 8'h0A; l[0] = 1'b1;
    d[6] = 8'h6E; l[6] = 1'b1;
    tick();
    check("rst_first_sel",   32'(out_sel),   32'd0);
    check("rst_first_valid", 32'(out_valid), 32'd1);
    v[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (xfer_ch == 6) v[6] = 1'b0;
    end

    // Random traffic; producers hold each beat until it is taken
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) begin
        if (!v[i] || xfer_ch == i) begin
          v[i] = ($urandom_range(0, 2) != 0);
          d[i] = 8'($urandom);
          l[i] = ($urandom_range(0, 2) == 0);
        end
      end
      tick();
    end

    // Drain: only close out packets already in flight, then stop
    out_ready = 1'b1;
    for (int c = 0; c < 200 && (m_lock >= 0 || v != 0); c++) begin
      for (int i = 0; i < 8; i++) begin
        if (xfer_ch == i) begin
          if (m_lock == i) begin l[i] = 1'b1; d[i] = 8'($urandom); end
          else v[i] = 1'b0;
        end else if (m_lock >= 0 && m_lock != i) begin
          v[i] = v[i];
        end
      end
      if (m_lock >= 0 && !v[m_lock]) begin
        v[m_lock] = 1'b1; l[m_lock] = 1'b1;
      end
      tick();
    end
    v = '0;
    for (int c = 0; c < 4; c++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_8x1_rr.md
Name: mux_8x1_rr

Overview:
- 8-input to 1-output stream multiplexer with round-robin arbitration and packet locking.
- Merges eight producer channels onto one output stream and tags each beat with its source channel index on out_sel.
- out_sel lets a downstream 1x8 demultiplexer route beats back out by channel.
- Registered output stage with valid/ready handshake on every port.

Parameters:
- DATA_W, 8, width of each channel's data beat.
- NUM_CH, 8, number of input channels; fixed at 8 (sel width 3); other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  8  per-channel beat valid; bit i = channel i.
- in_last  input  8  per-channel end-of-packet flag, qualified by in_valid.
- in_data  input  8*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  8  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  output beat data.
- out_sel  output  3  source channel index of the output beat.
- out_last  output  1  end-of-packet flag of the output beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (clk edge with rst_n=0): out_valid=0, out_data=0, out_sel=0, out_last=0, state=ARB, last_grant=7, so channel 0 has top priority. rst_n is sampled only on clk edges.
- Output register is one entry deep. can_load = !out_valid || out_ready.
- Grant selection, state ARB:
  - Scan channels last_grant+1, last_grant+2, ... wrapping mod 8.
  - First channel with in_valid=1 is the grant.
  - No valid channel means no grant.
- Grant selection, state LOCK: grant = locked channel only; other channels are ignored.
- in_ready[i] = can_load && (grant==i). It is combinational from in_valid, out_valid, out_ready and state. It never depends on in_ready itself.
- Transfer on channel i: in_valid[i] && in_ready[i] at a clk edge. On that edge:
  - out_data <= in_data slice i; out_sel <= i; out_last <= in_last[i]; out_valid <= 1; last_grant <= i.
- Latency: exactly 1 cycle from input transfer to out_valid. Sustained throughput is 1 beat/cycle when out_ready stays high.
- Output transfer without a new load: out_valid && out_ready with no input transfer that cycle -> out_valid <= 0. Data, sel and last hold their values.
- Backpressure: out_valid && !out_ready -> all in_ready=0. out_* stay stable until accepted.
- State machine:
  - ARB -> LOCK on a transfer with in_last=0; the locked channel is the granted one.
  - LOCK -> ARB on a transfer from the locked channel with in_last=1.
  - ARB with in_last=1 (single-beat packet) stays in ARB.
  - LOCK with the locked channel's in_valid=0 stays in LOCK, with no transfer. Other requesters stall; there is no timeout.
- Fairness: after a packet from channel i completes, channel i has lowest priority in the next arbitration.
- Simultaneous output accept and input transfer in one cycle: the new beat replaces the old one, and out_valid stays 1.
- Reset mid-packet: lock is dropped, the output beat is discarded and state returns to ARB. Upstream must restart its packets.
- Producers must hold in_valid and payload until their ready is seen. The block does not check this.

Decomposition:
- Shared package holds:
  - localparam NUM_CH=8 and SEL_W=3.
  - State enum {ST_ARB, ST_LOCK}.
  - Channel-index type logic [SEL_W-1:0].
- One natural sub-module: rr_arbiter_8, a combinational round-robin priority picker.
  - Inputs: req[7:0], last_grant[2:0].
  - Outputs: gnt_valid, gnt_idx[2:0].
  - Reusable by other stream blocks in the codebase.
- FSM, lock register and output register stay in mux_8x1_rr.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, all in_valid=0. After release, out_valid=0, out_sel=0 and in_ready=8'h00 every cycle.
- Round-robin, single beats, out_ready=1:
  - in_valid=8'hFF, in_last=8'hFF, in_data[i]=8'hA0+i held.
  - out_sel sequence is 0,1,2,...,7,0 on consecutive cycles; out_data=8'hA0..8'hA7.
  - Exactly one in_ready bit is high per cycle.
- Packet lock:
  - Ch2 sends 3 beats 8'h11,8'h22,8'h33 with in_last=0,0,1; ch5 is valid throughout.
  - Output is ch2 beats back-to-back with out_sel=2; out_last=1 only on 8'h33.
  - Ch5 (out_sel=5) follows next; in_ready[5] stays 0 during ch2's packet.
- Backpressure:
  - out_ready=0 for 4 cycles with a beat pending from ch3 (8'h5A).
  - out_data=8'h5A and out_sel=3 are stable and in_ready=8'h00 throughout.
  - On out_ready=1 the beat is accepted and the next beat loads in the same cycle.
- Lock stall: ch1 sends a beat with last=0, then drops in_valid for 3 cycles while ch4 is valid. in_ready[4] stays 0 and no output is produced until ch1 resumes and completes its packet.
- Reset mid-packet: assert rst_n=0 while locked to ch6 with out_valid=1. Next cycle out_valid=0 and state is ARB; after release, channel 0 wins first when ch0 and ch6 are both valid.
